// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Handshake and result bundle for the sequential binary-to-BCD
//               converter.
//               master : drives start/bin_in, observes the result
//               slave  : the converter itself
//   start    - request a conversion (accepted only while ready=1)
//   bin_in   - unsigned value to convert, WIDTH_BIN bits
//   ready    - converter idle and able to accept start
//   done     - one-cycle pulse, result outputs updated
//   bcd_out  - DIGITS packed BCD digits, digit 0 in [3:0]
//   overflow - value did not fit in DIGITS decimal digits
//   digit_nz - leading-zero blanking mask, bit 0 always set
// Revision    : 1.0  initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int WIDTH_BIN = 20,
    parameter int DIGITS    = 6
);
    logic                   start;
    logic [WIDTH_BIN-1:0]   bin_in;
    logic                   ready;
    logic                   done;
    logic [4*DIGITS-1:0]    bcd_out;
    logic                   overflow;
    logic [DIGITS-1:0]      digit_nz;

    modport master (
        output start,
        output bin_in,
        input  ready,
        input  done,
        input  bcd_out,
        input  overflow,
        input  digit_nz
    );

    modport slave (
        input  start,
        input  bin_in,
        output ready,
        output done,
        output bcd_out,
        output overflow,
        output digit_nz
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential double-dabble binary-to-BCD converter. One
//               adjust-and-shift step per clock, WIDTH_BIN steps per value.
//               Flags values that exceed DIGITS decimal digits and produces a
//               leading-zero blanking mask for the digit renderer.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - bin2bcd_seq_if.slave (start/bin_in in; ready, done,
//                      bcd_out, overflow, digit_nz out; all outputs registered)
// Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH_BIN = 20,
    parameter int DIGITS    = 6
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bin2bcd_seq_if.slave    bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH_BIN + 1);
    localparam int TOT_W = BCD_W + WIDTH_BIN;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [BCD_W-1:0]       bcd_acc_q,   bcd_acc_d;
    logic [WIDTH_BIN-1:0]   bin_acc_q,   bin_acc_d;
    logic                   ovf_acc_q,   ovf_acc_d;
    logic [BCD_W-1:0]       bcd_out_q,   bcd_out_d;
    logic                   overflow_q,  overflow_d;
    logic [DIGITS-1:0]      digit_nz_q,  digit_nz_d;
    logic                   done_q,      done_d;

    logic [BCD_W-1:0]       w_bcd_adj;
    logic [TOT_W-1:0]       w_shifted;
    logic [BCD_W-1:0]       w_final_bcd;
    logic [DIGITS-1:0]      w_nz;

    // Add-3 correction on each digit before the shift.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_bcd_adj[4*g +: 4] = (bcd_acc_q[4*g +: 4] >= 4'd5)
                                       ? bcd_acc_q[4*g +: 4] + 4'd3
                                       : bcd_acc_q[4*g +: 4];
        end
    endgenerate

    // Shift the whole {bcd, bin} register as one vector so WIDTH_BIN=1
    // needs no special-case slicing.
    assign w_shifted   = {w_bcd_adj[BCD_W-2:0], bin_acc_q, 1'b0};
    assign w_final_bcd = w_shifted[TOT_W-1 -: BCD_W];

    // Blanking mask: digit i is shown when it or any higher digit is
    // nonzero. Digit 0 is always shown so a zero value renders as "0".
    always_comb begin
        w_nz = '0;
        w_nz[DIGITS-1] = |w_final_bcd[BCD_W-1 -: 4];
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_nz[i] = (|w_final_bcd[4*i +: 4]) | w_nz[i+1];
        end
        w_nz[0] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bcd_acc_d  = bcd_acc_q;
        bin_acc_d  = bin_acc_q;
        ovf_acc_d  = ovf_acc_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        digit_nz_d = digit_nz_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    bcd_acc_d = '0;
                    bin_acc_d = bus.bin_in;
                    cnt_d     = CNT_W'(WIDTH_BIN);
                    ovf_acc_d = 1'b0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_acc_d, bin_acc_d} = w_shifted;
                // A bit leaving the top digit is a decimal carry past
                // DIGITS digits, i.e. the value does not fit.
                ovf_acc_d = ovf_acc_q | w_bcd_adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_out_d  = w_final_bcd;
                    overflow_d = ovf_acc_d;
                    digit_nz_d = w_nz;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bcd_acc_q  <= '0;
            bin_acc_q  <= '0;
            ovf_acc_q  <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
            digit_nz_q <= DIGITS'(1);
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bcd_acc_q  <= bcd_acc_d;
            bin_acc_q  <= bin_acc_d;
            ovf_acc_q  <= ovf_acc_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
            digit_nz_q <= digit_nz_d;
            done_q     <= done_d;
        end
    end

    // ready decodes the state flop directly; the done cycle is already IDLE,
    // which is what lets a back-to-back start be accepted there.
    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_out_q;
    assign bus.overflow = overflow_q;
    assign bus.digit_nz = digit_nz_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Two instances: the
//               default 20-bit/6-digit converter and a 20-bit/7-digit one.
//               Expected results come from a decimal-arithmetic model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

    localparam int W        = 20;
    localparam int D6       = 6;
    localparam int D7       = 7;
    localparam int LATENCY  = W + 1;
    localparam int TIMEOUT  = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH_BIN(W), .DIGITS(D6)) if6 ();
    bin2bcd_seq_if #(.WIDTH_BIN(W), .DIGITS(D7)) if7 ();

    bin2bcd_seq #(.WIDTH_BIN(W), .DIGITS(D6)) u_dut6 (
        .clk (clk),
        .rst (rst),
        .bus (if6.slave)
    );

    bin2bcd_seq #(.WIDTH_BIN(W), .DIGITS(D7)) u_dut7 (
        .clk (clk),
        .rst (rst),
        .bus (if7.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (plain decimal arithmetic) ----------
    function automatic logic [63:0] model_bcd(input longint v, input int nd);
        logic [63:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint v, input int nd);
        longint p;
        p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return (v >= p);
    endfunction

    function automatic logic [63:0] model_nz(input logic [63:0] bcd, input int nd);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < nd; i++) m[i] = ((bcd >> (4*i)) != 0);
        m[0] = 1'b1;
        return m;
    endfunction

    // ---------------- default-instance helpers ----------------------------
    // Called just after a falling edge; returns just after the falling edge
    // following the accepting edge.
    task automatic launch6(input logic [W-1:0] v);
        chk("ready_idle", 64'(if6.ready), 64'd1);
        if6.start  = 1'b1;
        if6.bin_in = v;
        @(negedge clk);
        if6.start  = 1'b0;
        chk("ready_busy", 64'(if6.ready), 64'd0);
    endtask

    // Waits for done (edges since accept start at lat0), then checks the
    // result. Scrambles bin_in while busy. Returns in the done cycle.
    task automatic finish6(input logic [W-1:0] v, input int lat0, input string tag);
        int lat;
        logic [63:0] eb;
        lat = lat0;
        while (if6.done !== 1'b1 && lat < TIMEOUT) begin
            if6.bin_in = W'($urandom);
            @(negedge clk);
            lat++;
        end
        eb = model_bcd(longint'(v), D6);
        chk({tag, "_latency"},  64'(lat),          64'(LATENCY));
        chk({tag, "_bcd"},      64'(if6.bcd_out),  eb);
        chk({tag, "_overflow"}, 64'(if6.overflow), 64'(model_ovf(longint'(v), D6)));
        chk({tag, "_digit_nz"}, 64'(if6.digit_nz), model_nz(eb, D6));
        chk({tag, "_ready_done"}, 64'(if6.ready),  64'd1);
    endtask

    task automatic count_dones6(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (if6.done === 1'b1) n++;
        end
    endtask

    initial begin
        int          ndone;
        int          lat7;
        logic [W-1:0] rv;
        logic [63:0] eb7;

        if6.start = 1'b0; if6.bin_in = '0;
        if7.start = 1'b0; if7.bin_in = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",    64'(if6.ready),    64'd1);
        chk("rst_done",     64'(if6.done),     64'd0);
        chk("rst_bcd",      64'(if6.bcd_out),  64'd0);
        chk("rst_overflow", 64'(if6.overflow), 64'd0);
        chk("rst_digit_nz", 64'(if6.digit_nz), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed values
        launch6(W'(0));       finish6(W'(0), 1, "zero");
        @(negedge clk); chk("done_single_pulse", 64'(if6.done), 64'd0);
        launch6(W'(123456));  finish6(W'(123456), 1, "v123456");
        @(negedge clk);
        launch6(W'(999999));  finish6(W'(999999), 1, "v999999");
        @(negedge clk);
        launch6(W'(1048575)); finish6(W'(1048575), 1, "vmax");
        @(negedge clk);

        // Back-to-back: new start issued in the done cycle
        launch6(W'(305));     finish6(W'(305), 1, "v305");
        launch6(W'(7));       finish6(W'(7), 1, "b2b_v7");
        @(negedge clk); chk("b2b_done_drop", 64'(if6.done), 64'd0);

        // Start while busy is ignored
        launch6(W'(4321));
        repeat (5) @(negedge clk);
        if6.start = 1'b1; if6.bin_in = W'(42);
        @(negedge clk);
        if6.start = 1'b0;
        finish6(W'(4321), 7, "ignore_busy");
        count_dones6(30, ndone);
        chk("ignore_extra_done", 64'(ndone), 64'd0);

        // Reset mid-conversion aborts without a done pulse
        launch6(W'(777777));
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", 64'(if6.ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",    64'(if6.ready),    64'd1);
        chk("abort_done",     64'(if6.done),     64'd0);
        chk("abort_bcd",      64'(if6.bcd_out),  64'd0);
        chk("abort_overflow", 64'(if6.overflow), 64'd0);
        chk("abort_digit_nz", 64'(if6.digit_nz), 64'd1);
        count_dones6(30, ndone);
        chk("abort_no_done", 64'(ndone), 64'd0);
        launch6(W'(59));      finish6(W'(59), 1, "after_abort_v59");
        @(negedge clk);

        // Randomized values across the full 20-bit range
        for (int k = 0; k < 10; k++) begin
            rv = (k % 2 == 0) ? W'($urandom_range(0, 999999))
                              : W'($urandom_range(0, (1 << W) - 1));
            launch6(rv);
            finish6(rv, 1, "rand");
            @(negedge clk);
        end

        // Seven-digit instance: 2^20-1 fits, no overflow
        chk("d7_ready_idle", 64'(if7.ready), 64'd1);
        if7.start = 1'b1; if7.bin_in = W'(1048575);
        @(negedge clk);
        if7.start = 1'b0;
        lat7 = 1;
        while (if7.done !== 1'b1 && lat7 < TIMEOUT) begin
            @(negedge clk);
            lat7++;
        end
        eb7 = model_bcd(64'd1048575, D7);
        chk("d7_latency",  64'(lat7),          64'(LATENCY));
        chk("d7_bcd",      64'(if7.bcd_out),   eb7);
        chk("d7_overflow", 64'(if7.overflow),  64'(model_ovf(64'd1048575, D7)));
        chk("d7_digit_nz", 64'(if7.digit_nz),  model_nz(eb7, D7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
